// File: rtl/pixel_blend_writer.sv
// Composites a DVI pixel with its warped CCD counterpart, maps (x,y) to a linear
// frame-buffer address and queues the result for a req/ack write port.
module pixel_blend_writer #(
  parameter int DEPTH = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19
) (
  input  logic          clk_25,
  input  logic          rst,
  input  logic          val,
  input  logic [9:0]    sync_x,
  input  logic [9:0]    sync_y,
  input  logic [4:0]    dvi_r,
  input  logic [5:0]    dvi_g,
  input  logic [4:0]    dvi_b,
  input  logic [4:0]    ccd_r,
  input  logic [5:0]    ccd_g,
  input  logic [4:0]    ccd_b,
  input  logic [1:0]    mode,
  input  logic [4:0]    alpha,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  input  logic          wr_ack,
  output logic          overflow,
  output logic          frame_done
);

  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     H_RES_BITS = 32'(H_RES);
  localparam logic [10:0]     H_LIM      = 11'(H_RES);
  localparam logic [10:0]     V_LIM      = 11'(V_RES);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(H_RES * V_RES - 1);
  localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(DEPTH);

  // ---------------- address: y*H_RES as a sum of shifted copies of y ----------------
  logic [AW-1:0] y_ext;
  logic [AW-1:0] row_terms [AW];
  logic [AW-1:0] pix_addr;

  assign y_ext = AW'(sync_y);

  generate
    for (genvar gi = 0; gi < AW; gi++) begin : g_row_term
      if (H_RES_BITS[gi]) begin : g_set
        assign row_terms[gi] = y_ext << gi;
      end else begin : g_clr
        assign row_terms[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    pix_addr = AW'(sync_x);
    for (int i = 0; i < AW; i++) begin
      pix_addr = pix_addr + row_terms[i];
    end
  end

  // ---------------- compositing ----------------
  logic [4:0]  a_w;
  logic [4:0]  inv_w;
  logic [8:0]  mix_r;
  logic [9:0]  mix_g;
  logic [8:0]  mix_b;
  logic [15:0] dvi_pix;
  logic [15:0] ccd_pix;
  logic [15:0] blended;
  logic [15:0] pix_data;
  logic        in_range;

  assign a_w     = (alpha > 5'd16) ? 5'd16 : alpha;
  assign inv_w   = 5'd16 - a_w;
  assign mix_r   = 9'(ccd_r) * 9'(a_w) + 9'(dvi_r) * 9'(inv_w);
  assign mix_g   = 10'(ccd_g) * 10'(a_w) + 10'(dvi_g) * 10'(inv_w);
  assign mix_b   = 9'(ccd_b) * 9'(a_w) + 9'(dvi_b) * 9'(inv_w);
  assign blended = {5'(mix_r >> 4), 6'(mix_g >> 4), 5'(mix_b >> 4)};
  assign dvi_pix = {dvi_r, dvi_g, dvi_b};
  assign ccd_pix = {ccd_r, ccd_g, ccd_b};

  always_comb begin
    pix_data = dvi_pix;
    case (mode)
      2'd0:    pix_data = dvi_pix;
      2'd1:    pix_data = ccd_pix;
      2'd2:    pix_data = blended;
      default: pix_data = (ccd_pix == 16'h0000) ? dvi_pix : ccd_pix;
    endcase
  end

  assign in_range = ({1'b0, sync_x} < H_LIM) && ({1'b0, sync_y} < V_LIM);

  // ---------------- stage 1 ----------------
  logic          s1_valid_reg;
  logic [AW-1:0] s1_addr_reg;
  logic [15:0]   s1_data_reg;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= val && in_range;
      if (val && in_range) begin
        s1_addr_reg <= pix_addr;
        s1_data_reg <= pix_data;
      end
    end
  end

  // ---------------- write queue ----------------
  logic [AW-1:0] q_addr_reg [DEPTH];
  logic [15:0]   q_data_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  logic          overflow_reg;
  logic          frame_done_reg;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign pop     = wr_req && wr_ack;
  // A pop frees the slot in the same edge, so a full queue still accepts.
  assign push_ok = s1_valid_reg && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + (PW + 1)'(1);
      2'b01:   count_next = count_reg - (PW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_reg[i] <= '0;
        q_data_reg[i] <= '0;
      end
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        q_addr_reg[wr_ptr_reg] <= s1_addr_reg;
        q_data_reg[wr_ptr_reg] <= s1_data_reg;
        wr_ptr_reg             <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (s1_valid_reg && full && !pop) begin
        overflow_reg <= 1'b1;
      end
      count_reg      <= count_next;
      frame_done_reg <= pop && (wr_addr == LAST_ADDR);
    end
  end

  assign wr_req     = (count_reg != '0);
  assign wr_addr    = q_addr_reg[rd_ptr_reg];
  assign wr_data    = q_data_reg[rd_ptr_reg];
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pixel_blend_writer.sv
// Directed bench for pixel_blend_writer: a queue-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_pixel_blend_writer;

  localparam int DEPTH = 4;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int AW    = 19;

  logic          clk_25 = 1'b0;
  logic          rst;
  logic          val;
  logic [9:0]    sync_x;
  logic [9:0]    sync_y;
  logic [4:0]    dvi_r;
  logic [5:0]    dvi_g;
  logic [4:0]    dvi_b;
  logic [4:0]    ccd_r;
  logic [5:0]    ccd_g;
  logic [4:0]    ccd_b;
  logic [1:0]    mode;
  logic [4:0]    alpha;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ack;
  logic          overflow;
  logic          frame_done;

  always #20 clk_25 = ~clk_25;

  pixel_blend_writer #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES), .AW(AW)) dut (
    .clk_25(clk_25), .rst(rst), .val(val), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .mode(mode), .alpha(alpha),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .overflow(overflow), .frame_done(frame_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } entry_t;

  entry_t mq[$];
  entry_t pend;
  bit     pend_v  = 0;
  bit     m_ovf   = 0;
  bit     m_fd    = 0;
  bit     started = 0;

  function automatic entry_t model_pix(input int x, input int y, input logic [15:0] dvi,
                                       input logic [15:0] ccd, input int md, input int al);
    entry_t e;
    int a, dr, dg, db, cr, cg, cb, r, g, b;
    dr = int'(dvi[15:11]); dg = int'(dvi[10:5]); db = int'(dvi[4:0]);
    cr = int'(ccd[15:11]); cg = int'(ccd[10:5]); cb = int'(ccd[4:0]);
    a  = (al > 16) ? 16 : al;
    case (md)
      0: begin r = dr; g = dg; b = db; end
      1: begin r = cr; g = cg; b = cb; end
      2: begin
        r = (cr * a + dr * (16 - a)) / 16;
        g = (cg * a + dg * (16 - a)) / 16;
        b = (cb * a + db * (16 - a)) / 16;
      end
      default: begin
        if (ccd == 16'h0000) begin r = dr; g = dg; b = db; end
        else begin r = cr; g = cg; b = cb; end
      end
    endcase
    e.addr = AW'(y * H_RES + x);
    e.data = {r[4:0], g[5:0], b[4:0]};
    return e;
  endfunction

  task automatic model_step();
    bit pop, full;
    if (rst) begin
      mq.delete();
      pend_v  = 0;
      m_ovf   = 0;
      m_fd    = 0;
      started = 1;
      return;
    end
    pop  = (mq.size() != 0) && wr_ack;
    full = (mq.size() == DEPTH);
    m_fd = pop && (mq[0].addr == AW'(H_RES * V_RES - 1));
    if (pop) void'(mq.pop_front());
    if (pend_v) begin
      if (!full || pop) mq.push_back(pend);
      else m_ovf = 1;
    end
    pend_v = val && (int'(sync_x) < H_RES) && (int'(sync_y) < V_RES);
    if (pend_v)
      pend = model_pix(int'(sync_x), int'(sync_y), {dvi_r, dvi_g, dvi_b},
                       {ccd_r, ccd_g, ccd_b}, int'(mode), int'(alpha));
  endtask

  initial begin
    forever begin
      @(posedge clk_25);
      model_step();
      @(negedge clk_25);
      if (started) begin
        chk("cyc_wr_req", wr_req, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("cyc_wr_addr", wr_addr, mq[0].addr);
          chk("cyc_wr_data", wr_data, mq[0].data);
        end
        chk("cyc_overflow", overflow, m_ovf);
        chk("cyc_frame_done", frame_done, m_fd);
      end
    end
  end

  // ---------------- stimulus ----------------
  int drained[$];

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input logic [15:0] dvi,
                         input logic [15:0] ccd, input int md, input int al);
    sync_x = 10'(x);
    sync_y = 10'(y);
    {dvi_r, dvi_g, dvi_b} = dvi;
    {ccd_r, ccd_g, ccd_b} = ccd;
    mode  = 2'(md);
    alpha = 5'(al);
    val   = 1'b1;
  endtask

  task automatic send(input int x, input int y, input logic [15:0] dvi,
                      input logic [15:0] ccd, input int md, input int al);
    set_pix(x, y, dvi, ccd, md, al);
    tick();
    val = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    drained.delete();
    wr_ack = 1'b1;
    while (wr_req === 1'b1 && guard < 20) begin
      drained.push_back(int'(wr_addr));
      tick();
      guard++;
    end
    wr_ack = 1'b0;
    chk("drain_empty", wr_req, 1'b0);
  endtask

  initial begin
    rst = 1'b1; val = 1'b0; wr_ack = 1'b0;
    sync_x = '0; sync_y = '0; mode = '0; alpha = '0;
    {dvi_r, dvi_g, dvi_b} = '0;
    {ccd_r, ccd_g, ccd_b} = '0;
    tick();
    tick();
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // passthrough
    send(5, 2, 16'hF800, 16'h07E0, 0, 0);
    chk("latency_n1_req", wr_req, 0);
    tick();
    chk("pass_req", wr_req, 1);
    chk("pass_addr", wr_addr, 1285);
    chk("pass_data", wr_data, 16'hF800);
    drain();
    send(5, 2, 16'hF800, 16'h07E0, 1, 0);
    tick();
    chk("ccd_data", wr_data, 16'h07E0);
    drain();

    // blend: dvi={31,0,10}, ccd={1,63,10}
    send(7, 0, 16'hF80A, 16'h0FEA, 2, 8);
    tick();
    chk("blend_a8", wr_data, 16'h83EA);
    drain();
    send(7, 0, 16'hF80A, 16'h0FEA, 2, 20);
    tick();
    chk("blend_a20", wr_data, 16'h0FEA);
    drain();

    // chroma key
    send(1, 1, 16'h1234, 16'h0000, 3, 0);
    tick();
    chk("key_black", wr_data, 16'h1234);
    drain();
    send(1, 1, 16'h1234, 16'h0001, 3, 0);
    tick();
    chk("key_nonblack", wr_data, 16'h0001);
    drain();

    // range boundaries
    send(640, 0, 16'hAAAA, 16'h5555, 0, 0);
    send(0, 480, 16'hAAAA, 16'h5555, 0, 0);
    tick();
    tick();
    chk("oob_no_req", wr_req, 0);
    chk("oob_no_ovf", overflow, 0);

    // last pixel and frame_done
    send(639, 479, 16'hABCD, 16'h0000, 0, 0);
    tick();
    chk("last_addr", wr_addr, 307199);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("fd_pulse", frame_done, 1);
    chk("fd_queue_empty", wr_req, 0);
    tick();
    chk("fd_single", frame_done, 0);

    // backpressure
    for (int i = 0; i < 6; i++) send(i, 1, 16'h0100 + 16'(i), 16'h0000, 0, 0);
    tick();
    tick();
    chk("bp_overflow", overflow, 1);
    chk("bp_head", wr_addr, 640);
    tick();
    chk("bp_head_stable", wr_addr, 640);
    chk("bp_req", wr_req, 1);
    drain();
    chk("bp_drain_count", drained.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_drain_addr", (i < drained.size()) ? drained[i] : -1, 640 + i);

    // reset mid-stream
    for (int i = 0; i < 3; i++) send(10 + i, 3, 16'h2222, 16'h0000, 0, 0);
    tick();
    chk("mid_req_before", wr_req, 1);
    rst = 1'b1;
    set_pix(20, 3, 16'h3333, 16'h0000, 0, 0);
    wr_ack = 1'b1;
    tick();
    rst = 1'b0; val = 1'b0; wr_ack = 1'b0;
    chk("mid_rst_req", wr_req, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_fd", frame_done, 0);
    tick();
    tick();
    chk("post_rst_idle", wr_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_blend_writer.md
Name: pixel_blend_writer

Overview:
- Downstream consumer of the sync controller. Takes each validated pixel pair: the DVI source pixel plus the homography-warped CCD pixel at the same screen coordinate.
- Composites the pair per a selectable mode and converts (x,y) to a linear frame-buffer address.
- Queues results in a small FIFO and drains them to the frame-buffer write port using a req/ack handshake.
- Sits between the sync controller and the SDRAM/SRAM frame-buffer arbiter.

Parameters:
- DEPTH, 4, write-queue entries; power of two, >= 2.
- H_RES, 640, active pixels per line; also the address stride.
- V_RES, 480, active lines per frame.
- AW, 19, frame-buffer address width; must satisfy H_RES*V_RES <= 2^AW.

Ports:
- clk_25  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- val  in  1  one-cycle strobe; the pixel fields below are valid this cycle.
- sync_x  in  10  screen x of the pixel.
- sync_y  in  10  screen y of the pixel.
- dvi_r/dvi_g/dvi_b  in  5/6/5  DVI pixel, RGB565.
- ccd_r/ccd_g/ccd_b  in  5/6/5  warped CCD pixel, RGB565.
- mode  in  2  composite select; sampled on val.
- alpha  in  5  CCD weight 0..16; sampled on val.
- wr_req  out  1  write request; high while the queue is non-empty.
- wr_addr  out  AW  head entry address.
- wr_data  out  16  head entry data {r,g,b}.
- wr_ack  in  1  arbiter accepts the head entry this cycle.
- overflow  out  1  sticky; set when a pixel is dropped because the queue is full.
- frame_done  out  1  one-cycle pulse when address H_RES*V_RES-1 is acked.

Behaviour:
- Reset: wr_req=0, wr_addr=0, wr_data=0, overflow=0, frame_done=0. Queue pointers and count cleared; the stage-1 register is invalidated. Reset mid-stream discards all pending entries with no writes issued, and overrides any simultaneous val or wr_ack.
- Stage 1: registered on clk_25 when val=1.
  - Range check: if sync_x>=H_RES or sync_y>=V_RES, the pixel is discarded. It produces no entry and does not set overflow.
  - Address: sync_y*H_RES+sync_x, truncated to AW bits. Implement with shifts/adds; no multiplier.
  - mode 0: output = dvi.
  - mode 1: output = ccd.
  - mode 2: per channel, (ccd*a + dvi*(16-a))>>4. a=min(alpha,16). Truncating shift; intermediate widths hold the full product (e.g. 10 bits for the 6-bit g channel).
  - mode 3 (chroma key): output = dvi if ccd=={0,0,0}, else ccd.
- Stage 2: a valid stage-1 result pushes into the queue on the next edge.
  - Latency: val at cycle N gives wr_req=1 at cycle N+2 if the queue was empty.
- Queue: FIFO of DEPTH entries, each {AW-bit address, 16-bit data}.
  - wr_req = (count!=0), combinational from registered state.
  - wr_addr/wr_data always show the head entry; they are held stable while wr_req=1 and wr_ack=0.
  - Pop on wr_req & wr_ack. wr_ack while wr_req=0 is ignored.
  - Push and pop in the same cycle: both occur and count is unchanged. This holds even when full, so the push is accepted.
  - Push when full with no pop: the entry is dropped and overflow<=1. overflow stays set until rst.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- frame_done: registered; asserted the cycle after a pop whose address equals H_RES*V_RES-1. Single-cycle pulse.
- No other state machine. The stage-1 valid bit and the queue count form the control state.

Test Plan:
- Passthrough: mode=0, val with x=5, y=2, dvi=16'hF800, ccd=16'h07E0 -> wr_req high 2 cycles later, wr_addr=1285, wr_data=16'hF800. Then mode=1 with the same pixel -> wr_data=16'h07E0.
- Blend: mode=2, alpha=8, dvi_r=31, ccd_r=1, dvi_g=0, ccd_g=63, dvi_b=10, ccd_b=10 -> r=16, g=31, b=10. Also alpha=20 -> output equals ccd exactly.
- Chroma key: mode=3, ccd=0, dvi=16'h1234 -> wr_data=16'h1234. Same with ccd=16'h0001 -> wr_data=16'h0001.
- Backpressure: wr_ack=0, 6 consecutive val pixels with DEPTH=4 -> 4 entries held, overflow=1, head stable. Then wr_ack=1 -> exactly the first 4 addresses drain in order, then wr_req=0.
- Boundaries: x=640,y=0 and x=0,y=480 -> no write, overflow unchanged. x=639,y=479 acked -> wr_addr=307199 and frame_done pulses for exactly 1 cycle.
- Reset mid-stream: 3 entries queued, rst=1 for 1 cycle together with val=1 and wr_ack=1 -> all outputs 0 next cycle, no further writes, overflow cleared.
